// File: rtl/lut_pkg.sv
// Shared types and default sizes for the LUT reader/loader pair.
// Defaults here must match the embedding datapath's LUT geometry.
package lut_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2
   } lut_state_t;

   localparam int LUT_DATA_WIDTH = 8;
   localparam int LUT_DATA_DEPTH = 16;

endpackage

// File: rtl/lut_regfile.sv
// DATA_DEPTH x DATA_WIDTH register file: synchronous write, 1-cycle registered read
// (read-before-write on same address), synchronous active-low clear of all entries.
module lut_regfile #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DATA_DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
   logic                  w_raddr_ok;

   // Non-power-of-two depths leave holes in the address space that must read as 0.
   assign w_raddr_ok = (32'(raddr) < DATA_DEPTH);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int i = 0; i < DATA_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            r_mem[waddr] <= wdata;
         end
         rdata <= w_raddr_ok ? r_mem[raddr] : '0;
      end
   end

endmodule

// File: rtl/lut_loader.sv
// Streams DATA_DEPTH words (valid/ready, 1 word/cycle, stalls freely on in_valid) into a LUT,
// then serves 1-cycle registered reads. Optional LUT_LOADER_CHECKSUM_EN adds a 16-bit sum of the load.
module lut_loader
   import lut_pkg::*;
#(
   parameter  int DATA_WIDTH = LUT_DATA_WIDTH,
   parameter  int DATA_DEPTH = LUT_DATA_DEPTH,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  done,
   output logic                  loaded,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef LUT_LOADER_CHECKSUM_EN
   output logic [15:0]           checksum,
`endif
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

   lut_state_t            r_state;
   lut_state_t            w_next_state;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic                  w_beat;
   logic                  w_last;
   logic                  w_enter_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      loaded       = 1'b0;
      w_enter_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = LOAD;
               w_enter_load = 1'b1;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (r_wr_addr == LAST_ADDR)) begin
               w_next_state = LOADED;
            end
         end
         LOADED: begin
            loaded = 1'b1;
            if (start) begin
               w_next_state = LOAD;
               w_enter_load = 1'b1;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign w_beat = in_valid && in_ready;
   assign w_last = (r_wr_addr == LAST_ADDR);
   assign done   = w_beat && w_last;

   // The final beat leaves the address parked at the last entry; it never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_addr <= '0;
      end else if (w_enter_load) begin
         r_wr_addr <= '0;
      end else if (w_beat && !w_last) begin
         r_wr_addr <= r_wr_addr + 1'b1;
      end
   end

`ifdef LUT_LOADER_CHECKSUM_EN
   logic [15:0] r_checksum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_checksum <= '0;
      end else if (w_enter_load) begin
         r_checksum <= '0;
      end else if (w_beat) begin
         r_checksum <= r_checksum + 16'(in_data);
      end
   end

   assign checksum = r_checksum;
`endif

   lut_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH)
   ) u_regfile (
      .clk   (clk),
      .clr_n (rst_n),
      .we    (w_beat),
      .waddr (r_wr_addr),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Write-side counterpart of the sequential LUT reader.
- Accepts a stream of DATA_DEPTH weight words over a valid/ready handshake and writes them in order (address 0 upward) into an internal register-file LUT.
- Signals completion, then serves random-access reads to the embedding datapath.
- Lets weights be loaded at run time instead of being fixed in a ROM.

Parameters:
DATA_WIDTH, 8, width of each weight word
DATA_DEPTH, 16, number of LUT entries (≥2; need not be a power of two)
ADDR_WIDTH, $clog2(DATA_DEPTH), local, address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a load sequence (level-sampled)
in_data  input  DATA_WIDTH  incoming weight word
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
done  output  1  one-cycle pulse on the final accepted beat
loaded  output  1  LUT holds a complete, valid image
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, wr_addr=0.
  - in_ready=0, done=0, loaded=0, rd_data=0.
  - All LUT entries cleared to 0.
  - Reset mid-load abandons the load; the partial image is discarded.
- FSM states: IDLE, LOAD, LOADED.
  - IDLE: start=1 -> LOAD, wr_addr=0.
  - LOAD: in_ready=1 combinationally while in this state.
    - Beat accepted when in_valid && in_ready: mem[wr_addr] <= in_data, wr_addr increments.
    - Beat with wr_addr==DATA_DEPTH-1: done=1 in that same cycle (combinational, like the reader's done), next state LOADED.
    - in_valid=0 stalls indefinitely with no timeout; wr_addr holds.
    - start is ignored in LOAD.
  - LOADED: loaded=1, in_ready=0.
    - start=1 -> LOAD with wr_addr=0 and loaded=0 from the next cycle.
    - Old contents stay readable until overwritten.
- in_valid outside LOAD: ignored, no write.
- Throughput: one word per cycle. A back-to-back load of N words takes N cycles after entering LOAD.
- Read port:
  - rd_data <= mem[rd_addr] on every clk edge, independent of state; latency 1 cycle.
  - rd_addr ≥ DATA_DEPTH returns 0.
  - Same-cycle write and read of the same address returns the old value (read-before-write).
- wr_addr never wraps. LOAD exits exactly at DATA_DEPTH-1, so no extra beats are accepted.

Optional Feature:
- Macro: LUT_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum[15:0] = mod-2^16 sum of all in_data beats accepted in the current load, zero-extended.
  - Cleared to 0 on reset and on the IDLE/LOADED -> LOAD transition.
  - Final value is stable from the cycle after done until the next load starts.
- Without the macro: the port and accumulator do not exist; all other behaviour is identical.

Decomposition:
- Package lut_pkg:
  - lut_state_t enum {IDLE, LOAD, LOADED}.
  - Default DATA_WIDTH/DATA_DEPTH constants, shared with the reader.
- Sub-module lut_regfile: DATA_DEPTH x DATA_WIDTH storage with
  - synchronous write (we, waddr, wdata),
  - registered read (raddr, rdata),
  - synchronous active-low clear.
- lut_loader keeps the FSM, address counter, handshake and optional checksum.

Test Plan:
- Back-to-back load, DEPTH=16:
  - Stimulus: start pulse, then in_valid held high with data 0x10..0x1F.
  - Expect in_ready high 16 cycles, done exactly on the 0x1F beat, loaded=1 the next cycle.
  - Reading addr 0..15 returns 0x10..0x1F at 1-cycle latency.
- Stalled load:
  - Stimulus: in_valid toggles 1,0,0,1,... with data 0xA0+i.
  - Expect only valid beats written, wr_addr holding during gaps, done after the 16th accepted beat, mem[i]=0xA0+i.
- Reset mid-load:
  - Stimulus: rst_n=0 after 7 beats.
  - Expect loaded=0, in_ready=0, all reads return 0x00.
  - A new start plus 16 beats loads correctly.
- Reload from LOADED:
  - Stimulus: after loading 0x10..0x1F, start again and send 0x55 x16.
  - Expect loaded to drop the cycle after start, old data readable until overwritten, final reads all 0x55.
- Ignored traffic and out-of-range read:
  - Stimulus: in_valid=1 with data 0xFF while in IDLE or LOADED; rd_addr=15 with DATA_DEPTH=12.
  - Expect no write and in_ready=0; rd_data=0.
- Checksum, LUT_LOADER_CHECKSUM_EN defined:
  - Stimulus: load 16 x 0xFF.
  - Expect checksum=0x0FF0 after done; checksum resets to 0 on the next start.
